// File: rtl/sprite_motion_ctl.sv
// sprite_motion_ctl: once-per-frame car position/speed/scroll update.
// Ports: pclk, rst (sync, high), vblnk_in, enable, btn_left/right/up/down
//        in; xpos, ypos, speed, road_offset, wall_hit, update_done out.
module sprite_motion_ctl #(
   parameter int SCREEN_W   = 800,
   parameter int RECT_WIDTH = 128,
   parameter int X_INIT     = 336,
   parameter int Y_INIT     = 472,
   parameter int MAX_SPEED  = 8,
   parameter int ACCEL_DIV  = 4,
   parameter int STEER_STEP = 4
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        vblnk_in,
   input  logic        enable,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_up,
   input  logic        btn_down,
   output logic [10:0] xpos,
   output logic [10:0] ypos,
   output logic [3:0]  speed,
   output logic [9:0]  road_offset,
   output logic        wall_hit,
   output logic        update_done
);

   typedef enum logic [2:0] {
      IDLE, WAIT, ACCEL, MOVE, CLAMP, COMMIT
   } state_t;

   localparam int ACW = (ACCEL_DIV > 1) ? $clog2(ACCEL_DIV) : 1;
   localparam logic [ACW-1:0] ACC_LAST = ACW'(ACCEL_DIV - 1);
   localparam logic [3:0] SPD_MAX = 4'(MAX_SPEED);
   localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - RECT_WIDTH);
   localparam logic signed [11:0] STEP = 12'(STEER_STEP);

   state_t state_q, state_d;
   logic vblnk_prev_q;
   logic [ACW-1:0] acc_q, acc_d;
   logic [3:0] spd_q, spd_d;
   logic [3:0] spdn_q, spdn_d;
   logic signed [11:0] xs_q, xs_d;
   logic hit_q, hit_d;
   logic [10:0] x_q, x_d;
   logic [10:0] ypos_q;
   logic [9:0] off_q, off_d;
   logic [9:0] offn_q, offn_d;
   logic wall_q, wall_d;
   logic done_q, done_d;
   logic tick;
   logic signed [11:0] xbase;

   assign tick  = vblnk_in & ~vblnk_prev_q;
   assign xbase = $signed({1'b0, x_q});

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      spd_d   = spd_q;
      spdn_d  = spdn_q;
      xs_d    = xs_q;
      hit_d   = hit_q;
      x_d     = x_q;
      off_d   = off_q;
      offn_d  = offn_q;
      wall_d  = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable) state_d = WAIT;
         end
         WAIT: begin
            // enable wins over a coincident tick
            if (!enable)   state_d = IDLE;
            else if (tick) state_d = ACCEL;
         end
         ACCEL: begin
            state_d = MOVE;
            hit_d   = 1'b0;
            if (acc_q == ACC_LAST) begin
               acc_d = '0;
               if (btn_up && !btn_down)
                  spdn_d = (spd_q < SPD_MAX) ? spd_q + 4'd1 : SPD_MAX;
               else if (btn_up && btn_down)
                  spdn_d = spd_q;
               else
                  // brake and coasting friction both step down
                  spdn_d = (spd_q != 4'd0) ? spd_q - 4'd1 : 4'd0;
            end else begin
               acc_d  = acc_q + 1'b1;
               spdn_d = spd_q;
            end
         end
         MOVE: begin
            state_d = CLAMP;
            xs_d    = xbase;
            if (spdn_q != 4'd0 && btn_left && !btn_right)
               xs_d = xbase - STEP;
            else if (spdn_q != 4'd0 && btn_right && !btn_left)
               xs_d = xbase + STEP;
            offn_d = off_q + 10'(spdn_q);
         end
         CLAMP: begin
            state_d = COMMIT;
            if (xs_q < 0) begin
               xs_d   = '0;
               hit_d  = 1'b1;
               spdn_d = spdn_q >> 1;
            end else if (xs_q > X_MAX) begin
               xs_d   = X_MAX;
               hit_d  = 1'b1;
               spdn_d = spdn_q >> 1;
            end
         end
         COMMIT: begin
            state_d = WAIT;
            x_d     = xs_q[10:0];
            spd_d   = spdn_q;
            off_d   = offn_q;
            done_d  = 1'b1;
            wall_d  = hit_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q      <= IDLE;
         vblnk_prev_q <= 1'b0;
         acc_q        <= '0;
         spd_q        <= '0;
         spdn_q       <= '0;
         xs_q         <= '0;
         hit_q        <= 1'b0;
         x_q          <= 11'(X_INIT);
         ypos_q       <= 11'(Y_INIT);
         off_q        <= '0;
         offn_q       <= '0;
         wall_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         vblnk_prev_q <= vblnk_in;
         acc_q        <= acc_d;
         spd_q        <= spd_d;
         spdn_q       <= spdn_d;
         xs_q         <= xs_d;
         hit_q        <= hit_d;
         x_q          <= x_d;
         ypos_q       <= ypos_q;
         off_q        <= off_d;
         offn_q       <= offn_d;
         wall_q       <= wall_d;
         done_q       <= done_d;
      end
   end

   assign xpos        = x_q;
   assign ypos        = ypos_q;
   assign speed       = spd_q;
   assign road_offset = off_q;
   assign wall_hit    = wall_q;
   assign update_done = done_q;

endmodule

// File: tb/tb_sprite_motion_ctl.sv
// tb_sprite_motion_ctl: directed frames with a commit scoreboard.
// Stimulus pushes expected commits; a negedge monitor pops and checks.
module tb_sprite_motion_ctl;

   logic pclk = 1'b0;
   logic rst = 1'b1;
   logic vblnk_in = 1'b0;
   logic enable = 1'b0;
   logic bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0;
   logic [10:0] xpos, ypos;
   logic [3:0] speed;
   logic [9:0] road_offset;
   logic wall_hit, update_done;

   sprite_motion_ctl dut (
      .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .enable(enable),
      .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd),
      .xpos(xpos), .ypos(ypos), .speed(speed),
      .road_offset(road_offset), .wall_hit(wall_hit),
      .update_done(update_done)
   );

   always #5 pclk = ~pclk;

   longint cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   typedef struct {
      int x; int spd; int off; bit hit; longint cyc;
   } exp_t;

   exp_t q[$];
   exp_t last;
   int tests = 0, fails = 0, n_done = 0;
   bit stable_on = 0;
   int m_x = 336, m_spd = 0, m_off = 0, m_acc = 0;

   task automatic chk(string name, int act, int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   always @(negedge pclk) begin
      exp_t e;
      if (!rst) begin
         if (update_done) begin
            n_done++;
            if (q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_commit: got commit at %0d want none",
                        cyc);
            end else begin
               e = q.pop_front();
               chk("xpos", int'(xpos), e.x);
               chk("speed", int'(speed), e.spd);
               chk("road_offset", int'(road_offset), e.off);
               chk("wall_hit", int'(wall_hit), int'(e.hit));
               chk("latency_cycle", int'(cyc), int'(e.cyc));
               last = e;
            end
         end else if (stable_on) begin
            chk("hold_xpos", int'(xpos), last.x);
            chk("hold_speed", int'(speed), last.spd);
            chk("hold_offset", int'(road_offset), last.off);
            chk("hold_wall_hit", int'(wall_hit), 0);
            chk("ypos", int'(ypos), 472);
         end
      end
   end

   task automatic model_reset();
      m_x = 336; m_spd = 0; m_off = 0; m_acc = 0;
      last = '{x: 336, spd: 0, off: 0, hit: 1'b0, cyc: 0};
   endtask

   task automatic model(bit l, bit r, bit u, bit d, longint t0);
      int sn, x;
      bit hit;
      if (m_acc == 3) begin
         m_acc = 0;
         if (u && !d)     sn = (m_spd < 8) ? m_spd + 1 : 8;
         else if (u && d) sn = m_spd;
         else             sn = (m_spd > 0) ? m_spd - 1 : 0;
      end else begin
         m_acc++;
         sn = m_spd;
      end
      x = m_x;
      if (sn > 0 && l && !r)      x = x - 4;
      else if (sn > 0 && r && !l) x = x + 4;
      m_off = (m_off + sn) % 1024;
      hit = 0;
      if (x < 0) begin x = 0; hit = 1; end
      else if (x > 672) begin x = 672; hit = 1; end
      if (hit) sn = sn / 2;
      m_x = x;
      m_spd = sn;
      q.push_back('{x: x, spd: sn, off: m_off, hit: hit, cyc: t0 + 5});
   endtask

   // called and returns at posedge+1
   task automatic frame(bit l, bit r, bit u, bit d, bit upd);
      longint t0;
      bl = l; br = r; bu = u; bd = d;
      vblnk_in = 1'b1;
      t0 = cyc;
      if (upd) model(l, r, u, d, t0);
      repeat (8) @(posedge pclk);
      #1 vblnk_in = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      chk("commit_pending", q.size(), 0);
      if (q.size() != 0) q.delete();
   endtask

   task automatic check_reset_vals(string tag);
      chk({tag, "_xpos"}, int'(xpos), 336);
      chk({tag, "_ypos"}, int'(ypos), 472);
      chk({tag, "_speed"}, int'(speed), 0);
      chk({tag, "_offset"}, int'(road_offset), 0);
      chk({tag, "_wall_hit"}, int'(wall_hit), 0);
      chk({tag, "_update_done"}, int'(update_done), 0);
   endtask

   initial begin
      int nd;
      model_reset();
      repeat (3) @(posedge pclk);
      #1 check_reset_vals("reset");
      rst = 1'b0;
      stable_on = 1;
      enable = 1'b1;
      repeat (2) @(posedge pclk);
      #1;

      // coasting from reset
      for (int i = 0; i < 3; i++) frame(0, 0, 0, 0, 1);
      chk("idle_xpos", int'(xpos), 336);
      chk("idle_speed", int'(speed), 0);
      chk("idle_offset", int'(road_offset), 0);

      // accelerate to ceiling
      for (int i = 0; i < 40; i++) frame(0, 0, 1, 0, 1);
      chk("accel_speed", int'(speed), 8);
      chk("accel_offset", int'(road_offset), 208);

      // offset wraps past 1023
      for (int i = 0; i < 110; i++) frame(0, 0, 1, 0, 1);
      chk("wrap_offset", int'(road_offset), 64);

      // steer right up to the wall
      for (int i = 0; i < 84; i++) frame(0, 1, 1, 0, 1);
      chk("right_xpos", int'(xpos), 672);
      chk("right_speed", int'(speed), 8);
      frame(0, 1, 1, 0, 1);
      chk("wall_speed", int'(speed), 4);
      for (int i = 0; i < 3; i++) frame(0, 1, 1, 0, 1);
      chk("wall_speed_end", int'(speed), 0);
      chk("wall_xpos_end", int'(xpos), 672);

      // conflicting buttons
      for (int i = 0; i < 8; i++) frame(0, 0, 1, 0, 1);
      for (int i = 0; i < 8; i++) frame(1, 1, 1, 1, 1);
      chk("both_xpos", int'(xpos), 672);

      // stop, then no steering at standstill
      for (int i = 0; i < 12; i++) frame(0, 0, 0, 0, 1);
      chk("stop_speed", int'(speed), 0);
      for (int i = 0; i < 4; i++) frame(1, 0, 0, 0, 1);
      chk("standstill_xpos", int'(xpos), 672);

      // up to speed 3, then friction
      for (int i = 0; i < 20 && m_spd != 3; i++) frame(0, 0, 1, 0, 1);
      chk("reach3_speed", int'(speed), 3);
      for (int i = 0; i < 12; i++) frame(0, 0, 0, 0, 1);
      chk("friction_speed", int'(speed), 0);

      // reset while in MOVE
      bl = 1'b0; br = 1'b1; bu = 1'b1; bd = 1'b0;
      vblnk_in = 1'b1;
      repeat (2) @(posedge pclk);
      #1 rst = 1'b1;
      vblnk_in = 1'b0;
      model_reset();
      @(posedge pclk);
      #1 check_reset_vals("midreset");
      rst = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      frame(0, 0, 1, 0, 1);
      frame(0, 0, 1, 0, 1);

      // disabled: no commit, frozen outputs
      enable = 1'b0;
      repeat (2) @(posedge pclk);
      #1 nd = n_done;
      frame(0, 1, 1, 0, 0);
      frame(0, 1, 1, 0, 0);
      chk("disabled_commits", n_done - nd, 0);
      enable = 1'b1;
      repeat (2) @(posedge pclk);
      #1 frame(0, 0, 1, 0, 1);
      chk("resume_commits", n_done - nd, 1);

      chk("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, want finish by 2000000");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sprite_motion_ctl.md
# sprite_motion_ctl

Per-frame position and speed controller for the player car sprite. Samples the steering and pedal buttons once per frame at the start of vertical blanking. Updates the car's horizontal position, speed and road scroll offset. Drives the xpos/ypos configuration inputs of the sprite overlay stage, so the overlay never sees a position change mid-frame.

## Interface
Parameters:
- SCREEN_W, 800, visible width in pixels
- RECT_WIDTH, 128, sprite width in pixels
- X_INIT, 336, xpos after reset
- Y_INIT, 472, constant ypos value
- MAX_SPEED, 8, speed ceiling (≤15)
- ACCEL_DIV, 4, frames per speed step (≥1)
- STEER_STEP, 4, lateral pixels per frame while speed>0

Ports:
- pclk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- vblnk_in  in  1  vertical blanking from timing chain
- enable  in  1  game running; low freezes all state
- btn_left  in  1  steer left, level
- btn_right  in  1  steer right, level
- btn_up  in  1  accelerate, level
- btn_down  in  1  brake, level
- xpos  out  11  sprite left edge, registered
- ypos  out  11  sprite top edge, registered, always Y_INIT after reset
- speed  out  4  current speed, registered
- road_offset  out  10  road scroll accumulator, registered
- wall_hit  out  1  one-cycle pulse on a clamped commit
- update_done  out  1  one-cycle pulse on every commit

## Operation
- Frame tick: vblnk_prev is a register. tick = vblnk_in & ~vblnk_prev.
- FSM states: IDLE, WAIT, ACCEL, MOVE, CLAMP, COMMIT.
  - IDLE: hold everything. Go to WAIT when enable=1.
  - WAIT: go to ACCEL on tick. Go to IDLE when enable=0 (checked before tick).
  - ACCEL, MOVE, CLAMP, COMMIT each last exactly one cycle, then advance unconditionally. Enable is not sampled; an update in progress always completes.
- ACCEL:
  - acc_cnt increments. At ACCEL_DIV-1 it wraps to 0 and speed_nxt is set:
    - up only: speed+1, saturating at MAX_SPEED.
    - down only: speed−1, saturating at 0.
    - up and down together: no change.
    - neither: speed−1 (friction), saturating at 0.
  - Otherwise speed_nxt = speed.
- MOVE:
  - x_s is a 12-bit signed value.
  - x_s = xpos − STEER_STEP when left only and speed_nxt>0.
  - x_s = xpos + STEER_STEP when right only and speed_nxt>0.
  - Otherwise x_s = xpos, including when both are pressed.
  - off_nxt = road_offset + speed_nxt, mod 1024 (wraps naturally).
- CLAMP:
  - x_s<0 → 0, hit=1.
  - x_s>SCREEN_W−RECT_WIDTH → SCREEN_W−RECT_WIDTH, hit=1.
  - On hit, speed_nxt = speed_nxt>>1.
- COMMIT:
  - Load xpos, speed and road_offset.
  - update_done=1; wall_hit=hit.
  - Go to WAIT.
- Reset values:
  - xpos=X_INIT, ypos=Y_INIT, speed=0, road_offset=0.
  - acc_cnt=0, vblnk_prev=0, wall_hit=0, update_done=0, state IDLE.
- Reset mid-update aborts the sequence. All registers take their reset values on the next edge.

## Timing
- Cycle numbering: cycle 0 is the edge where vblnk_in is first sampled high.
  - vblnk_prev goes high at edge 1.
  - tick is combinationally true during cycle 0.
  - FSM moves to ACCEL at edge 1.
  - State sequence: ACCEL (cycle 1), MOVE (2), CLAMP (3), COMMIT (4).
- New xpos, speed and road_offset are visible after edge 5, together with update_done=1 for that one cycle.
- Latency from vblnk rise to new outputs: 5 pclk. This is far shorter than the blanking interval.
- Buttons are sampled in ACCEL (pedals) and MOVE (steering). Changes during the rest of the frame are ignored.
- Exactly one update per frame. No second tick is possible until vblnk_in falls and rises again.
- A vblnk rise while the FSM is not in WAIT (IDLE or mid-sequence) is ignored; no update for that frame.
- Outputs change only at commit. Between commits they are stable for the whole active frame.

## Test plan
- Reset, enable=1, no buttons, 3 frames → xpos=336, speed=0, road_offset=0; update_done pulses once per frame, 5 cycles after each vblnk rise.
- btn_up held, ACCEL_DIV=4, 40 frames → speed steps up every 4th frame, saturates at 8. road_offset equals the running sum of committed speeds mod 1024; check wrap past 1023.
- speed=8, btn_right held → xpos +4 per frame until 672. The clamping frame pulses wall_hit and halves speed to 4. Speed also halves on each later clamped frame.
- btn_left and btn_right together, and btn_up and btn_down together → xpos unchanged, speed unchanged across the acc_cnt wrap frame.
- speed=0, btn_left held → xpos unchanged (no steering at standstill). Release btn_up at speed 3 → friction brings speed to 0 within 12 frames.
- Assert rst during MOVE → next cycle all outputs at reset values, FSM in IDLE. Deassert enable during WAIT → no commit on the next vblnk; outputs frozen.
